// File: rtl/control_word_sequencer.sv
// control_word_sequencer
//
// Takes the 33-bit control word chosen by the instruction-class decoders
// and applies it to the datapath. This block holds the instruction
// register, the 2-bit micro-state fed back to the decoders, the status
// register, and the fetch handshake with instruction memory.
//
// Optional feature macro: CW_SEQ_RETIRE_COUNT_EN
//   defined   -> instr_retired_o counts retired instructions (wraps at 2^32)
//   undefined -> instr_retired_o is tied to 0 and no counter is built
//
// Ports
//   clock_i, reset_i          system clock, synchronous active-high reset
//   fetch_req_o / fetch_ack_i fetch handshake; instr_in_i valid on ack
//   ir_o, state_o, status_o   instruction register, micro-state and status
//                             flags, all fed back to the decoders
//   cw_in_i, k_in_i           selected control word and constant
//   status_in_i               ALU flags, loaded on EXEC exit if requested
//   stall_i                   holds the EXEC phase
//   alu_*, rf_*, ram_*, pc_*, sa/sb/wa, k_out_o   datapath controls
//   instr_retired_o           retired-instruction count
//
// Phase FSM
//   state  | meaning
//   FETCH  | request instruction, load ir on ack, micro-state <= 00
//   DECODE | latch control word and constant from the decoders
//   EXEC   | drive datapath from latched word; exit when stall_i is low

module control_word_sequencer #(
    parameter int STATUS_W = 5,
    parameter int K_W      = 64
) (
    input  logic                clock_i,
    input  logic                reset_i,
    output logic                fetch_req_o,
    input  logic                fetch_ack_i,
    input  logic [31:0]         instr_in_i,
    output logic [31:0]         ir_o,
    output logic [1:0]          state_o,
    output logic [STATUS_W-1:0] status_o,
    input  logic [32:0]         cw_in_i,
    input  logic [K_W-1:0]      k_in_i,
    input  logic [STATUS_W-1:0] status_in_i,
    input  logic                stall_i,
    output logic                alu_en_o,
    output logic                alu_bs_o,
    output logic [4:0]          alu_fs_o,
    output logic                rf_b_en_o,
    output logic [4:0]          sa_o,
    output logic [4:0]          sb_o,
    output logic [4:0]          wa_o,
    output logic                rf_w_o,
    output logic                ram_en_o,
    output logic                ram_w_o,
    output logic                pc_en_o,
    output logic [1:0]          pc_fs_o,
    output logic                pc_sel_o,
    output logic [K_W-1:0]      k_out_o,
    output logic [31:0]         instr_retired_o
);

    typedef enum logic [1:0] {
        PH_FETCH  = 2'd0,
        PH_DECODE = 2'd1,
        PH_EXEC   = 2'd2
    } phase_t;

    phase_t                phase_q, phase_d;
    logic [31:0]           ir_q, ir_d;
    logic [1:0]            state_q, state_d;
    logic [STATUS_W-1:0]   status_q, status_d;
    logic [32:0]           cr_q, cr_d;
    logic [K_W-1:0]        k_q, k_d;

    // Control-register fields used by the sequencer itself.
    logic                  cr_status_load;
    logic [1:0]            cr_ns;
    logic                  in_exec;

    assign cr_status_load = cr_q[2];
    assign cr_ns          = cr_q[1:0];
    assign in_exec        = (phase_q == PH_EXEC);

    always_comb begin
        phase_d  = phase_q;
        ir_d     = ir_q;
        state_d  = state_q;
        status_d = status_q;
        cr_d     = cr_q;
        k_d      = k_q;
        case (phase_q)
            PH_FETCH: begin
                if (fetch_ack_i) begin
                    ir_d    = instr_in_i;
                    state_d = 2'b00;
                    phase_d = PH_DECODE;
                end
            end
            PH_DECODE: begin
                cr_d    = cw_in_i;
                k_d     = k_in_i;
                phase_d = PH_EXEC;
            end
            PH_EXEC: begin
                if (!stall_i) begin
                    if (cr_status_load) begin
                        status_d = status_in_i;
                    end
                    state_d = cr_ns;
                    // A nonzero next-state re-enters DECODE so the decoders
                    // can produce the control word for that micro-state.
                    phase_d = (cr_ns == 2'b00) ? PH_FETCH : PH_DECODE;
                end
            end
            default: begin
                phase_d = PH_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            phase_q  <= PH_FETCH;
            ir_q     <= '0;
            state_q  <= '0;
            status_q <= '0;
            cr_q     <= '0;
            k_q      <= '0;
        end else begin
            phase_q  <= phase_d;
            ir_q     <= ir_d;
            state_q  <= state_d;
            status_q <= status_d;
            cr_q     <= cr_d;
            k_q      <= k_d;
        end
    end

`ifdef CW_SEQ_RETIRE_COUNT_EN
    logic        retire;
    logic [31:0] retired_q, retired_d;

    assign retire    = in_exec && !stall_i && (cr_ns == 2'b00);
    assign retired_d = retire ? retired_q + 32'd1 : retired_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign instr_retired_o = retired_q;
`else
    assign instr_retired_o = 32'd0;
`endif

    assign fetch_req_o = (phase_q == PH_FETCH);
    assign ir_o        = ir_q;
    assign state_o     = state_q;
    assign status_o    = status_q;
    assign k_out_o     = k_q;

    // cr_q keeps the last word outside EXEC, so every datapath control is
    // gated by the phase to keep strobes and enables low in FETCH/DECODE.
    assign alu_en_o  = in_exec & cr_q[32];
    assign alu_bs_o  = in_exec & cr_q[31];
    assign alu_fs_o  = in_exec ? cr_q[30:26] : 5'd0;
    assign rf_b_en_o = in_exec & cr_q[25];
    assign sa_o      = in_exec ? cr_q[24:20] : 5'd0;
    assign sb_o      = in_exec ? cr_q[19:15] : 5'd0;
    assign wa_o      = in_exec ? cr_q[14:10] : 5'd0;
    assign rf_w_o    = in_exec & cr_q[9];
    assign ram_en_o  = in_exec & cr_q[8];
    assign ram_w_o   = in_exec & cr_q[7];
    assign pc_en_o   = in_exec & cr_q[6];
    assign pc_fs_o   = in_exec ? cr_q[5:4] : 2'd0;
    assign pc_sel_o  = in_exec & cr_q[3];

endmodule

// File: tb/tb_control_word_sequencer.sv
module tb_control_word_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic        fetch_ack;
    logic [31:0] instr_in;
    logic [31:0] ir;
    logic [1:0]  state;
    logic [4:0]  status;
    logic [32:0] cw_in;
    logic [63:0] k_in;
    logic [4:0]  status_in;
    logic        stall;
    logic        alu_en, alu_bs, rf_b_en, rf_w, ram_en, ram_w, pc_en, pc_sel;
    logic [4:0]  alu_fs, sa, sb, wa;
    logic [1:0]  pc_fs;
    logic [63:0] k_out;
    logic [31:0] instr_retired;

    control_word_sequencer #(.STATUS_W(5), .K_W(64)) dut (
        .clock_i(clk), .reset_i(rst),
        .fetch_req_o(fetch_req), .fetch_ack_i(fetch_ack), .instr_in_i(instr_in),
        .ir_o(ir), .state_o(state), .status_o(status),
        .cw_in_i(cw_in), .k_in_i(k_in), .status_in_i(status_in), .stall_i(stall),
        .alu_en_o(alu_en), .alu_bs_o(alu_bs), .alu_fs_o(alu_fs), .rf_b_en_o(rf_b_en),
        .sa_o(sa), .sb_o(sb), .wa_o(wa), .rf_w_o(rf_w), .ram_en_o(ram_en),
        .ram_w_o(ram_w), .pc_en_o(pc_en), .pc_fs_o(pc_fs), .pc_sel_o(pc_sel),
        .k_out_o(k_out), .instr_retired_o(instr_retired)
    );

    always #5 clk = ~clk;

    // Datapath bundle in the same bit order as cw_in[32:3].
    logic [29:0] dp;
    assign dp = {alu_en, alu_bs, alu_fs, rf_b_en, sa, sb, wa,
                 rf_w, ram_en, ram_w, pc_en, pc_fs, pc_sel};

    typedef struct {
        logic        freq;
        logic [1:0]  st;
        logic [31:0] ir;
        logic [4:0]  status;
        logic [29:0] dp;
        logic [63:0] k;
        logic [31:0] ret;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   drive_done = 1'b0;

    // Control words (MSB first: alu_en, alu_bs, alu_fs, rf_b_en, sa, sb, wa,
    // rf_w, ram_en, ram_w, pc_en, pc_fs, pc_sel, status_load, NS).
    localparam logic [32:0] CW_ADDI = {1'b1, 1'b1, 5'b01000, 1'b0, 5'd2, 5'd0, 5'd1,
                                       1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00};
    localparam logic [32:0] CW_A    = {1'b0, 1'b0, 5'b00011, 1'b1, 5'd4, 5'd5, 5'd0,
                                       1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b01};
    localparam logic [32:0] CW_B    = {1'b1, 1'b0, 5'b10001, 1'b0, 5'd7, 5'd0, 5'd9,
                                       1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
    localparam logic [32:0] CW_S    = {1'b1, 1'b0, 5'b00101, 1'b1, 5'd3, 5'd6, 5'd12,
                                       1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00};
    localparam logic [32:0] CW_R    = {1'b0, 1'b0, 5'b00000, 1'b0, 5'd8, 5'd0, 5'd0,
                                       1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00};

    localparam logic [31:0] I_ADDI = 32'h91000C41;
    localparam logic [31:0] I_MS   = 32'h12345678;
    localparam logic [31:0] I_S    = 32'hCAFEF00D;
    localparam logic [31:0] I_R    = 32'h0BADC0DE;

    function automatic logic [29:0] dpv(input logic [32:0] cw);
        return cw[32:3];
    endfunction

    function automatic logic [31:0] ret(input int n);
`ifdef CW_SEQ_RETIRE_COUNT_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the outputs expected during the current cycle, then advance.
    task automatic ex(input logic freq, input logic [1:0] st, input logic [31:0] eir,
                      input logic [4:0] es, input logic [29:0] edp, input logic [63:0] ek,
                      input logic [31:0] er, input string nm);
        exp_t e;
        e.freq = freq; e.st = st; e.ir = eir; e.status = es;
        e.dp = edp; e.k = ek; e.ret = er; e.name = nm;
        exp_q.push_back(e);
        tick();
    endtask

    task automatic chk(input string nm, input string fld, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "fetch_req", 64'(fetch_req), 64'(e.freq));
            chk(e.name, "state",     64'(state),     64'(e.st));
            chk(e.name, "ir",        64'(ir),        64'(e.ir));
            chk(e.name, "status",    64'(status),    64'(e.status));
            chk(e.name, "datapath",  64'(dp),        64'(e.dp));
            chk(e.name, "k_out",     k_out,          e.k);
            chk(e.name, "retired",   64'(instr_retired), 64'(e.ret));
        end
    end

    initial begin
        rst = 1'b1; fetch_ack = 1'b0; instr_in = '0; cw_in = '0;
        k_in = '0; status_in = '0; stall = 1'b0;

        // Reset held two cycles
        tick();
        ex(1, 0, 0, 0, 0, 0, ret(0), "reset");
        rst = 1'b0;

        // ADDI: FETCH with immediate ack, DECODE, EXEC, back to FETCH
        fetch_ack = 1; instr_in = I_ADDI; cw_in = CW_ADDI; k_in = 64'h5;
        ex(1, 0, 0, 0, 0, 0, ret(0), "addi_fetch");
        fetch_ack = 0; instr_in = 32'h0;
        ex(0, 0, I_ADDI, 0, 0, 0, ret(0), "addi_decode");
        status_in = 5'b11111;
        ex(0, 0, I_ADDI, 0, dpv(CW_ADDI), 64'h5, ret(0), "addi_exec");

        // Multi-state: NS=01 then NS=00
        fetch_ack = 1; instr_in = I_MS; cw_in = CW_A; k_in = 64'hAAAA;
        ex(1, 0, I_ADDI, 0, 0, 64'h5, ret(1), "addi_done");
        fetch_ack = 0;
        ex(0, 0, I_MS, 0, 0, 64'h5, ret(1), "ms_decode0");
        ex(0, 0, I_MS, 0, dpv(CW_A), 64'hAAAA, ret(1), "ms_exec0");
        cw_in = CW_B; k_in = 64'hBBBB;
        ex(0, 1, I_MS, 0, 0, 64'hAAAA, ret(1), "ms_decode1");
        ex(0, 1, I_MS, 0, dpv(CW_B), 64'hBBBB, ret(1), "ms_exec1");

        // Delayed ack: four cycles without ack
        instr_in = 32'hDEADBEEF; fetch_ack = 0;
        for (int i = 0; i < 4; i++)
            ex(1, 0, I_MS, 0, 0, 64'hBBBB, ret(2), "delayed_ack");

        // Status load with two stall cycles
        fetch_ack = 1; instr_in = I_S; cw_in = CW_S; k_in = 64'h1;
        ex(1, 0, I_MS, 0, 0, 64'hBBBB, ret(2), "stat_fetch");
        fetch_ack = 0; instr_in = 32'h0;
        ex(0, 0, I_S, 0, 0, 64'hBBBB, ret(2), "stat_decode");
        stall = 1; status_in = 5'b00001;
        ex(0, 0, I_S, 0, dpv(CW_S), 64'h1, ret(2), "stat_stall1");
        status_in = 5'b01001;
        ex(0, 0, I_S, 0, dpv(CW_S), 64'h1, ret(2), "stat_stall2");
        stall = 0; status_in = 5'b10110;
        ex(0, 0, I_S, 0, dpv(CW_S), 64'h1, ret(2), "stat_exit");

        // Reset during EXEC of a RAM write with status_load set
        fetch_ack = 1; instr_in = I_R; cw_in = CW_R; k_in = 64'h2; status_in = 5'b00000;
        ex(1, 0, I_S, 5'b10110, 0, 64'h1, ret(3), "stat_done");
        fetch_ack = 0;
        ex(0, 0, I_R, 5'b10110, 0, 64'h1, ret(3), "rst_decode");
        status_in = 5'b01010; rst = 1;
        ex(0, 0, I_R, 5'b10110, dpv(CW_R), 64'h2, ret(3), "rst_exec");

        // Ack coincident with reset: reset wins
        fetch_ack = 1; instr_in = 32'hFFFFFFFF;
        ex(1, 0, 0, 0, 0, 0, ret(0), "rst_after_exec");
        rst = 0; fetch_ack = 0;
        ex(1, 0, 0, 0, 0, 0, ret(0), "ack_with_reset");

        tick();
        drive_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!drive_done && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        @(negedge clk);
        checks++;
        if (!drive_done || exp_q.size() != 0) begin
            errors++;
            $display("FAIL completion actual=done:%0d pending:%0d required=done:1 pending:0",
                     drive_done, exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
